// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared widths and FSM state codes for the adder front end.
// Revision 1.0
`default_nettype none

package operand_entry_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = OPERAND_W + 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    CALC   = 2'd2,
    SHOW   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, hold-time debounce counter and rising-edge press pulse.
// Revision 1.0
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The stable level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~stable_dly_q;

endmodule

`default_nettype wire

// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: captures two switch operands on debounced load presses, latches the adder sum.
// Revision 1.0
`default_nettype none

module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPERAND_W-1:0] sw,
  input  logic                 btn_load,
  input  logic                 btn_clr,
  output logic [OPERAND_W-1:0] op_a,
  output logic [OPERAND_W-1:0] op_b,
  input  logic [RESULT_W-1:0]  sum_in,
  output logic [RESULT_W-1:0]  result,
  output logic                 result_valid,
  output logic [1:0]           state_o,
  output logic [7:0]           led
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic                 load_pulse;
  logic                 clr_pulse;
  logic [1:0]           unused_stable;
  state_e               state_q;
  state_e               state_d;
  logic [OPERAND_W-1:0] op_a_q;
  logic [OPERAND_W-1:0] op_a_d;
  logic [OPERAND_W-1:0] op_b_q;
  logic [OPERAND_W-1:0] op_b_d;
  logic [RESULT_W-1:0]  result_q;
  logic [RESULT_W-1:0]  result_d;
  logic                 valid_q;
  logic                 valid_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_load (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_load),
    .stable_o(unused_stable[0]),
    .press_o (load_pulse)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clr (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_clr),
    .stable_o(unused_stable[1]),
    .press_o (clr_pulse)
  );

  // Clear overrides everything; CALC ignores load so a stray pulse is never queued.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    valid_d  = valid_q;
    if (clr_pulse) begin
      state_d  = LOAD_A;
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD_A: if (load_pulse) begin
          op_a_d  = sw;
          state_d = LOAD_B;
        end
        LOAD_B: if (load_pulse) begin
          op_b_d  = sw;
          state_d = CALC;
        end
        CALC: begin
          result_d = sum_in;
          valid_d  = 1'b1;
          state_d  = SHOW;
        end
        SHOW: if (load_pulse) begin
          op_a_d  = sw;
          valid_d = 1'b0;
          state_d = LOAD_B;
        end
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state_o      = state_q;
  assign led          = {valid_q, state_q, result_q};

endmodule

`default_nettype wire

// File: tb/tb_operand_entry_fsm.sv
// tb_operand_entry_fsm: directed stimulus, window-based reference model and literal spot checks.
// Revision 1.0
`default_nettype none

module tb_operand_entry_fsm;

  localparam int N = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [3:0] sw       = 4'h0;
  logic       btn_load = 1'b0;
  logic       btn_clr  = 1'b0;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] sum_in;
  logic [4:0] result;
  logic       result_valid;
  logic [1:0] state_o;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sum_in = {1'b0, op_a} + {1'b0, op_b};

  operand_entry_fsm #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .btn_load    (btn_load),
    .btn_clr     (btn_clr),
    .op_a        (op_a),
    .op_b        (op_b),
    .sum_in      (sum_in),
    .result      (result),
    .result_valid(result_valid),
    .state_o     (state_o),
    .led         (led)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a button level is accepted once the last N synchronized
  // samples (raw delayed two edges) all disagree with the accepted level.
  logic [N+1:0] lh_l, lh_c;
  logic         st_l, st_c, sp_l, sp_c;
  logic         n_st_l, n_st_c, pl, pc;
  logic [3:0]   m_a, m_b, n_a, n_b;
  logic [4:0]   m_r, n_r;
  logic         m_v, n_v;
  logic [1:0]   m_ph, n_ph;

  function automatic logic win_differs(input logic [N+1:0] h, input logic s);
    for (int k = 1; k <= N; k++) begin
      if (h[k] == s) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb begin
    pl     = st_l & ~sp_l;
    pc     = st_c & ~sp_c;
    n_a    = m_a;
    n_b    = m_b;
    n_r    = m_r;
    n_v    = m_v;
    n_ph   = m_ph;
    n_st_l = win_differs(lh_l, st_l) ? ~st_l : st_l;
    n_st_c = win_differs(lh_c, st_c) ? ~st_c : st_c;
    if (pc) begin
      n_a = 4'h0; n_b = 4'h0; n_r = 5'h00; n_v = 1'b0; n_ph = 2'd0;
    end else if (m_ph == 2'd2) begin
      n_r = 5'(m_a) + 5'(m_b); n_v = 1'b1; n_ph = 2'd3;
    end else if (pl) begin
      if (m_ph == 2'd1) begin
        n_b = sw; n_ph = 2'd2;
      end else begin
        n_a = sw; n_v = 1'b0; n_ph = 2'd1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lh_l <= '0; lh_c <= '0;
      st_l <= 1'b0; st_c <= 1'b0; sp_l <= 1'b0; sp_c <= 1'b0;
      m_a <= 4'h0; m_b <= 4'h0; m_r <= 5'h00; m_v <= 1'b0; m_ph <= 2'd0;
    end else begin
      lh_l <= {lh_l[N:0], btn_load};
      lh_c <= {lh_c[N:0], btn_clr};
      sp_l <= st_l; sp_c <= st_c;
      st_l <= n_st_l; st_c <= n_st_c;
      m_a <= n_a; m_b <= n_b; m_r <= n_r; m_v <= n_v; m_ph <= n_ph;
    end
  end

  always @(negedge clk) begin
    chk("model_op_a", op_a, m_a);
    chk("model_op_b", op_b, m_b);
    chk("model_result", result, m_r);
    chk("model_valid", result_valid, m_v);
    chk("model_state", state_o, m_ph);
    chk("model_led", led, {m_v, m_ph, m_r});
  end

  task automatic press_load(input logic [3:0] v);
    sw = v; btn_load = 1'b1; tick(8);
    btn_load = 1'b0; tick(8);
  endtask

  task automatic press_clr();
    btn_clr = 1'b1; tick(8);
    btn_clr = 1'b0; tick(8);
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_led", led, 8'h00);
    chk("rst_state", state_o, 2'd0);
    chk("rst_ops", {op_a, op_b}, 8'h00);

    btn_load = 1'b1; tick(3); btn_load = 1'b0; tick(8);
    chk("short_press_state", state_o, 2'd0);

    sw = 4'h9; btn_load = 1'b1; tick(6);
    chk("op_a_edge6", op_a, 4'h0);
    tick(1);
    chk("op_a_edge7", op_a, 4'h9);
    chk("state_load_b", state_o, 2'd1);
    tick(1); btn_load = 1'b0; tick(8);

    sw = 4'h7; btn_load = 1'b1; tick(6);
    chk("state_before_b", state_o, 2'd1);
    tick(1);
    chk("op_b_7", op_b, 4'h7);
    chk("state_calc", state_o, 2'd2);
    tick(1);
    chk("state_show", state_o, 2'd3);
    chk("result_10", result, 5'h10);
    chk("valid_hi", result_valid, 1'b1);
    chk("led_f0", led, 8'hF0);
    btn_load = 1'b0; tick(8);

    press_load(4'hF); press_load(4'hF);
    chk("result_1e", result, 5'h1E);
    press_load(4'h1);
    chk("show_load_op_a", op_a, 4'h1);
    chk("show_load_valid", result_valid, 1'b0);
    chk("show_load_state", state_o, 2'd1);
    chk("show_load_result_kept", result, 5'h1E);
    press_load(4'h2);
    chk("result_03", result, 5'h03);

    press_clr();
    chk("clr_state", state_o, 2'd0);
    chk("clr_led", led, 8'h00);

    sw = 4'h5;
    repeat (2) begin
      btn_load = 1'b1; tick(2);
      btn_load = 1'b0; tick(2);
    end
    btn_load = 1'b1; tick(6);
    chk("bounce_edge6", op_a, 4'h0);
    tick(1);
    chk("bounce_edge7", op_a, 4'h5);
    tick(3); btn_load = 1'b0; tick(8);
    chk("bounce_one_pulse", state_o, 2'd1);

    sw = 4'h9; btn_clr = 1'b1; btn_load = 1'b1; tick(8);
    btn_clr = 1'b0; btn_load = 1'b0; tick(8);
    chk("clr_wins_op_a", op_a, 4'h0);
    chk("clr_wins_state", state_o, 2'd0);
    chk("clr_wins_op_b", op_b, 4'h0);

    press_load(4'h5); press_load(4'h7);
    chk("result_0c", result, 5'h0C);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_ops", {op_a, op_b}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    press_load(4'h3); press_load(4'h4);
    chk("post_rst_result", result, 5'h07);
    chk("post_rst_led", led, 8'hE7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
